// File: rtl/xdisplay_scan_pkg.sv
// xdisplay_scan_pkg: shared constants, converter states and BCD helper for the 7-segment scanner
package xdisplay_scan_pkg;

    localparam int DATA_W = 32;
    localparam logic [7:0] DISP_BLANK = 8'hFF;
    localparam int DISP_MAXVAL = 9999;
    localparam int DISP_NDIG = 4;

    typedef enum logic {IDLE, CONV} conv_state_t;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int n = 0; n < 4; n++)
            r[4*n +: 4] = (b[4*n +: 4] >= 4'd5) ? b[4*n +: 4] + 4'd3 : b[4*n +: 4];
        return r;
    endfunction

endpackage

// File: rtl/xdisplay_scan_if.sv
// xdisplay_scan_if: picoversat I/O bus slice seen by the display scanner
interface xdisplay_scan_if;
    import xdisplay_scan_pkg::*;

    logic              sel;
    logic              we;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (output sel, we, data_in, input data_out);
    modport slave  (input sel, we, data_in, output data_out);

endinterface

// File: rtl/xdisplay_scan_xbin2bcd.sv
// xbin2bcd: sequential 16-iteration double-dabble binary-to-BCD engine with restart on start
module xbin2bcd
    import xdisplay_scan_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] value_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bcd_o,
    output logic        ovf_o
);

    conv_state_t state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [31:0] shifted;

    // One iteration per CONV cycle; a start always wins and restarts from scratch
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        shifted = {add3(bcd_q), bin_q} << 1;
        if (state_q == CONV) begin
            {bcd_d, bin_d} = shifted;
            cnt_d   = cnt_q + 4'd1;
            state_d = (cnt_q == 4'd15) ? IDLE : CONV;
        end
        if (start_i) begin
            bin_d   = value_i;
            bcd_d   = '0;
            cnt_d   = '0;
            ovf_d   = value_i > 16'(DISP_MAXVAL);
            state_d = CONV;
        end
    end

    // Converter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // done and bcd_o present the 16th iteration's result so the caller commits on that same edge
    assign busy_o = (state_q == CONV);
    assign done_o = (state_q == CONV) && (cnt_q == 4'd15);
    assign bcd_o  = shifted[31:16];
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/xdisplay_scan.sv
// xdisplay_scan: 4-digit 7-segment scanner with BCD conversion; XDISP_LZB_EN enables leading-zero blanking
module xdisplay_scan
    import xdisplay_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    xdisplay_scan_if.slave   bus,
    output logic [3:0]       n_display_o,
    output logic [7:0]       digit_o
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]  presc_q, presc_d;
    logic [1:0]     idx_q, idx_d;
    logic [3:0][7:0] disp_q, disp_d;
    logic           ovf_q, ovf_d;
    logic [3:0]     n_display_q;
    logic [7:0]     digit_q;
    logic           busy, done, bcd_ovf;
    logic [15:0]    bcd;
    logic           unused_hi;

    xbin2bcd u_conv (
        .clk     (clk),
        .rst     (rst),
        .start_i (bus.sel && bus.we),
        .value_i (bus.data_in[15:0]),
        .busy_o  (busy),
        .done_o  (done),
        .bcd_o   (bcd),
        .ovf_o   (bcd_ovf)
    );

`ifdef XDISP_LZB_EN
    logic lead;
`endif

    // Commit all four digit codes at once when the converter finishes
    always_comb begin
        disp_d = disp_q;
        ovf_d  = done ? bcd_ovf : ovf_q;
        for (int d = 0; d < DISP_NDIG; d++)
            disp_d[d] = done ? (bcd_ovf ? DISP_BLANK : {4'b0, bcd[4*d +: 4]}) : disp_q[d];
`ifdef XDISP_LZB_EN
        lead = 1'b1;
        for (int d = DISP_NDIG - 1; d > 0; d--) begin
            lead = lead && (bcd[4*d +: 4] == 4'd0);
            if (done && lead)
                disp_d[d] = DISP_BLANK;
        end
`endif
    end

    // Prescaler wrap advances the scan position
    always_comb begin
        presc_d = (presc_q == PW'(REFRESH_DIV - 1)) ? '0 : presc_q + PW'(1);
        idx_d   = (presc_q == PW'(REFRESH_DIV - 1)) ? idx_q + 2'd1 : idx_q;
    end

    // Display register, scanner state and registered pad outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            ovf_q       <= 1'b0;
            n_display_q <= 4'b1110;
            digit_q     <= '0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            ovf_q       <= ovf_d;
            n_display_q <= ~(4'b0001 << idx_d);
            digit_q     <= disp_q[idx_d];
        end
    end

    assign unused_hi    = ^bus.data_in[DATA_W-1:16];
    assign bus.data_out = {{(DATA_W-2){1'b0}}, ovf_q, busy};
    assign n_display_o  = n_display_q;
    assign digit_o      = digit_q;

endmodule

// File: tb/tb_xdisplay_scan.sv
// tb_xdisplay_scan: directed self-checking bench for xdisplay_scan with a fast refresh divider
module tb_xdisplay_scan;
    import xdisplay_scan_pkg::*;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] n_display;
    logic [7:0] digit;
    int         checks = 0;
    int         errors = 0;
    logic       watch = 1'b0;
    logic       saw_4 = 1'b0;

    xdisplay_scan_if bus ();

    xdisplay_scan #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .n_display_o (n_display),
        .digit_o     (digit)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (watch && digit == 8'd4)
            saw_4 <= 1'b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_val(input logic [15:0] v);
        @(negedge clk);
        bus.sel     = 1'b1;
        bus.we      = 1'b1;
        bus.data_in = {16'hA5A5, v};
        @(negedge clk);
        bus.sel     = 1'b0;
        bus.we      = 1'b0;
    endtask

    task automatic busy_len(input string tag);
        int n;
        n = 0;
        while (bus.data_out[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, 16);
    endtask

    task automatic show(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] exp [4];
        logic [3:0] tgt;
        int n;
        exp = '{d0, d1, d2, d3};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tgt = ~(4'b0001 << i);
            n = 0;
            while (n_display !== tgt && n < 4 * DIV + 4) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("%s pos%0d sel", tag, i), n_display, tgt);
            check($sformatf("%s pos%0d digit", tag, i), digit, exp[i]);
        end
    endtask

    initial begin
        bus.sel     = 1'b0;
        bus.we      = 1'b0;
        bus.data_in = '0;
        repeat (3) @(negedge clk);
        check("reset n_display", n_display, 4'b1110);
        check("reset digit", digit, 8'd0);
        check("reset data_out", bus.data_out, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("scan hold", n_display, 4'b1110);
        @(posedge clk);
        #1 check("scan step", n_display, 4'b1101);

        write_val(16'd1234);
        check("1234 busy", bus.data_out[0], 1);
        busy_len("1234 busy len");
        check("1234 status", bus.data_out, 0);
        show("1234", 8'd4, 8'd3, 8'd2, 8'd1);

        write_val(16'd10000);
        busy_len("10000 busy len");
        check("10000 status", bus.data_out, 2);
        show("10000", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        write_val(16'd9999);
        busy_len("9999 busy len");
        check("9999 status", bus.data_out, 0);
        show("9999", 8'd9, 8'd9, 8'd9, 8'd9);

        watch = 1'b1;
        write_val(16'd42);
        write_val(16'd7);
        busy_len("restart busy len");
`ifdef XDISP_LZB_EN
        show("7", 8'd7, 8'hFF, 8'hFF, 8'hFF);
`else
        show("7", 8'd7, 8'd0, 8'd0, 8'd0);
`endif
        show("7 frame2", digit == 8'd7 ? 8'd7 : 8'd7, d_exp(1), d_exp(2), d_exp(3));
        watch = 1'b0;
        check("42 never shown", saw_4, 1'b0);

        write_val(16'd5);
        busy_len("5 busy len");
`ifdef XDISP_LZB_EN
        show("5", 8'd5, 8'hFF, 8'hFF, 8'hFF);
`else
        show("5", 8'd5, 8'd0, 8'd0, 8'd0);
`endif

        write_val(16'd0);
        busy_len("0 busy len");
`ifdef XDISP_LZB_EN
        show("0", 8'd0, 8'hFF, 8'hFF, 8'hFF);
`else
        show("0", 8'd0, 8'd0, 8'd0, 8'd0);
`endif

        write_val(16'd8765);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst n_display", n_display, 4'b1110);
        check("rst digit", digit, 8'd0);
        check("rst data_out", bus.data_out, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post rst status", bus.data_out, 0);
        show("post rst", 8'd0, 8'd0, 8'd0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [7:0] d_exp(input int pos);
`ifdef XDISP_LZB_EN
        return (pos == 0) ? 8'd7 : 8'hFF;
`else
        return (pos == 0) ? 8'd7 : 8'd0;
`endif
    endfunction

endmodule
